// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM initiator: FSM states, wait-counter width and
// the registered strobe bundle decoded from each state.
package sram_ctrl_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ACCESS,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;

    typedef struct packed {
        logic cs_n;
        logic oe_n;
        logic we_n;
        logic drive;
    } strobes_t;

    localparam strobes_t STB_IDLE = '{cs_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};

    // Bus drive is tied to the WR_* states only, so it can never overlap notOE.
    function automatic strobes_t strobes_for(input state_t s);
        strobes_t st;
        st = STB_IDLE;
        case (s)
            ST_RD_ACCESS: begin
                st.cs_n = 1'b0;
                st.oe_n = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                st.cs_n  = 1'b0;
                st.drive = 1'b1;
            end
            ST_WR_PULSE: begin
                st.cs_n  = 1'b0;
                st.we_n  = 1'b0;
                st.drive = 1'b1;
            end
            default: st = STB_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Valid/ready to asynchronous SRAM initiator: sequences notCS/notOE/notWE and
// the data bus from registered state so every strobe is glitch-free.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 1
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_notOE,
    output logic                  sram_notWE,
    output logic                  sram_notCS
);

    localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(READ_WAIT - 1);
    localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WRITE_WAIT - 1);

    state_t                state, state_nx;
    logic [WAIT_W-1:0]     cnt, cnt_nx;
    logic                  accept;
    logic                  capture;
    logic                  done;
    strobes_t              stb;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign accept = (state == ST_IDLE) && req_valid && req_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = req_write ? ST_WR_SETUP : ST_RD_ACCESS;
                    cnt_nx   = RD_LOAD;
                end
            end
            ST_RD_ACCESS: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                    capture  = 1'b1;
                    done     = 1'b1;
                end else begin
                    cnt_nx = cnt - WAIT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_nx = ST_WR_PULSE;
                cnt_nx   = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt == '0) begin
                    state_nx = ST_WR_HOLD;
                end else begin
                    cnt_nx = cnt - WAIT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                state_nx = ST_IDLE;
                done     = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Strobes and ready are registered from the next state, so they switch
    // on the same edge as the state register itself.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stb       <= STB_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            sram_addr <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            stb       <= strobes_for(state_nx);
            req_ready <= (state_nx == ST_IDLE);
            rsp_valid <= done;
            if (capture) begin
                rsp_rdata <= sram_data;
            end
            if (accept) begin
                sram_addr <= req_addr;
                wdata_q   <= req_wdata;
            end
        end
    end

    assign sram_notCS = stb.cs_n;
    assign sram_notOE = stb.oe_n;
    assign sram_notWE = stb.we_n;
    assign sram_data  = stb.drive ? wdata_q : 'z;

endmodule
